// File: rtl/de0_nano_onchip_arb_pkg.sv
// Shared types for the DE0-Nano on-chip RAM arbiter: requester id, FSM states,
// read-tag record and a saturating-counter helper for the statistics option.
package de0_nano_onchip_arb_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int BE_W           = DATA_W_DEFAULT / 8;

  typedef logic req_id_t;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    oor;
  } rd_tag_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
    return (en && value != 16'hFFFF) ? value + 16'd1 : value;
  endfunction

endpackage

// File: rtl/de0_nano_onchip_memory_arbiter_rr.sv
// Two-way round-robin grant: one-hot grant from a request vector, with the
// last winner remembered so the other requester wins the next contention.
module de0_nano_rr_arbiter2
  import de0_nano_onchip_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output req_id_t    rr_last_o
);

  req_id_t rr_last_q;
  req_id_t rr_last_d;

  // A requester wins when it asks and either the other is idle or it did not win last.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_gnt
      assign gnt_o[gi] = en_i && req_i[gi] &&
                         (!req_i[1 - gi] || rr_last_q != req_id_t'(gi));
    end
  endgenerate

  always_comb begin
    rr_last_d = rr_last_q;
    if (|gnt_o) begin
      rr_last_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  assign rr_last_o = rr_last_q;

endmodule

// File: rtl/de0_nano_onchip_memory_arbiter.sv
// Round-robin Avalon-MM arbiter for two requesters in front of the on-chip RAM,
// with out-of-range blocking and a zero-fill sequencer. Optional counters: ONCHIP_ARB_STATS_EN.
module de0_nano_onchip_memory_arbiter
  import de0_nano_onchip_arb_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 5120
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
`ifdef ONCHIP_ARB_STATS_EN
  input  logic                  stats_clear,
  output logic [15:0]           m0_grant_count,
  output logic [15:0]           m1_grant_count,
  output logic [15:0]           conflict_count,
`endif
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done
);

  localparam int                BEW       = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  rd_tag_t           tag_q, tag_d;
  logic              clear_done_q, clear_done_d;

  logic [1:0]        active;
  logic [1:0]        gnt;
  logic [1:0]        rdv;
  req_id_t           rr_last;
  req_id_t           win_id;
  req_id_t           sel_id;
  logic              arb_en;
  logic              any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [BEW-1:0]    sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;
  logic              sel_oor;
  logic [DATA_W-1:0] rdata;

  assign active = {m1_read | m1_write, m0_read | m0_write};
  assign arb_en = !reset && (state_q == RUN) && !clear_start;

  de0_nano_rr_arbiter2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .en_i      (arb_en),
    .req_i     (active),
    .gnt_o     (gnt),
    .rr_last_o (rr_last)
  );

  // Mux select follows the winner; with no grant it rests on m0.
  assign win_id  = (&active) ? ~rr_last : active[1];
  assign sel_id  = arb_en & win_id;
  assign any_gnt = |gnt;

  assign sel_addr  = sel_id ? m1_address    : m0_address;
  assign sel_be    = sel_id ? m1_byteenable : m0_byteenable;
  assign sel_wdata = sel_id ? m1_writedata  : m0_writedata;
  assign sel_write = sel_id ? m1_write      : m0_write;
  assign sel_oor   = {1'b0, sel_addr} >= DEPTH_EXT;

  always_comb begin
    mem_address    = sel_addr;
    mem_byteenable = sel_be;
    mem_writedata  = sel_wdata;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (!reset && state_q == CLEAR) begin
      mem_address    = clr_cnt_q;
      mem_byteenable = '1;
      mem_writedata  = '0;
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
    end else if (any_gnt && !sel_oor) begin
      mem_chipselect = 1'b1;
      mem_write      = sel_write;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clear_done_d = 1'b0;
    // Read+write together counts as a write, so only pure reads are tagged.
    tag_d.valid  = any_gnt && !sel_write;
    tag_d.id     = sel_id;
    tag_d.oor    = sel_oor;
    case (state_q)
      RUN: begin
        if (clear_start) begin
          state_d = CLEAR;
        end
      end
      default: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d      = RUN;
          clr_cnt_d    = '0;
          clear_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      clr_cnt_q    <= '0;
      tag_q        <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      tag_q        <= tag_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign rdata = tag_q.oor ? '0 : mem_readdata;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rdv
      assign rdv[gi] = tag_q.valid && (tag_q.id == req_id_t'(gi));
    end
  endgenerate

  assign m0_waitrequest   = !gnt[0];
  assign m1_waitrequest   = !gnt[1];
  assign m0_readdata      = rdata;
  assign m1_readdata      = rdata;
  assign m0_readdatavalid = rdv[0];
  assign m1_readdatavalid = rdv[1];
  assign mem_clken        = 1'b1;
  assign clear_busy       = (state_q == CLEAR);
  assign clear_done       = clear_done_q;

`ifdef ONCHIP_ARB_STATS_EN
  logic [15:0] g0_cnt_q, g1_cnt_q, conf_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      g0_cnt_q   <= '0;
      g1_cnt_q   <= '0;
      conf_cnt_q <= '0;
    end else begin
      g0_cnt_q   <= sat_inc(g0_cnt_q, gnt[0]);
      g1_cnt_q   <= sat_inc(g1_cnt_q, gnt[1]);
      conf_cnt_q <= sat_inc(conf_cnt_q, (state_q == RUN) && (&active));
    end
  end

  assign m0_grant_count = g0_cnt_q;
  assign m1_grant_count = g1_cnt_q;
  assign conflict_count = conf_cnt_q;
`endif

endmodule

// File: tb/tb_de0_nano_onchip_memory_arbiter.sv
// Bench for the on-chip RAM arbiter: directed vector table, clear/reset sequences,
// and randomized traffic checked against a memory/arbitration reference model.
module tb_de0_nano_onchip_memory_arbiter;

  localparam int DEPTH = 5120;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [12:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } req_t;

  typedef struct packed {
    req_t        q0;
    req_t        q1;
    logic        ew0;
    logic        ew1;
    logic        ecs;
    logic        ewe;
    logic [12:0] eaddr;
    logic        erv0;
    logic        erv1;
    logic [31:0] erd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [12:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata = 32'h0;
  logic        clear_start, clear_busy, clear_done;

  de0_nano_onchip_memory_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata),
    .clear_start      (clear_start),
    .clear_busy       (clear_busy),
    .clear_done       (clear_done)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Single-port RAM with one-cycle read latency.
  logic [31:0] ram [0:8191];
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      mem_readdata <= ram[mem_address];
    end
  end

  // Reference memory contents.
  logic [31:0] mdl [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic req_t rq(input logic r, input logic w, input logic [12:0] a,
                              input logic [3:0] be, input logic [31:0] d);
    req_t q;
    q.rd = r; q.wr = w; q.addr = a; q.be = be; q.data = d;
    return q;
  endfunction

  task automatic set_in(input req_t q0, input req_t q1);
    m0_read = q0.rd; m0_write = q0.wr; m0_address = q0.addr;
    m0_byteenable = q0.be; m0_writedata = q0.data;
    m1_read = q1.rd; m1_write = q1.wr; m1_address = q1.addr;
    m1_byteenable = q1.be; m1_writedata = q1.data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input req_t q);
    if (q.wr && q.addr < DEPTH) mdl[q.addr] = merge(mdl[q.addr], q.data, q.be);
  endtask

  task automatic do_write(input logic id, input logic [12:0] a, input logic [3:0] be,
                          input logic [31:0] d);
    req_t q, idle;
    q = rq(1'b0, 1'b1, a, be, d);
    idle = rq(1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
    tick();
    if (id) set_in(idle, q); else set_in(q, idle);
    @(negedge clk);
    chk("wr_wait", id ? m1_waitrequest : m0_waitrequest, 1'b0);
    model_write(q);
    $display("write m%0d addr=%0d be=%h data=%08h", id, a, be, d);
  endtask

  task automatic do_read(input logic id, input logic [12:0] a, input logic [31:0] exp);
    req_t q, idle;
    q = rq(1'b1, 1'b0, a, 4'hF, 32'h0);
    idle = rq(1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
    tick();
    if (id) set_in(idle, q); else set_in(q, idle);
    @(negedge clk);
    chk("rd_wait", id ? m1_waitrequest : m0_waitrequest, 1'b0);
    chk("rd_cs", mem_chipselect, a < DEPTH);
    tick();
    set_in(idle, idle);
    @(negedge clk);
    chk("rd_valid", id ? m1_readdatavalid : m0_readdatavalid, 1'b1);
    chk("rd_data", id ? m1_readdata : m0_readdata, exp);
    $display("read  m%0d addr=%0d data=%08h", id, a, id ? m1_readdata : m0_readdata);
  endtask

  vec_t tbl [26];

  initial begin
    req_t idle, r5, r10;
    int   wait_cnt, done_cnt, bad_clr, last_id;
    logic pend_v, pend_id;
    logic [31:0] pend_d;

    for (int i = 0; i < 8192; i++) ram[i] = {16'hA5A5, 16'(i)};
    for (int i = 0; i < DEPTH; i++) mdl[i] = {16'hA5A5, 16'(i)};

    idle = rq(1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
    r5   = rq(1'b1, 1'b0, 13'd5, 4'hF, 32'h0);
    r10  = rq(1'b1, 1'b0, 13'd10, 4'hF, 32'h0);

    //            q0                                    q1                                  w0 w1 cs we addr    v0 v1 rdata
    tbl[0]  = '{rq(0,1,13'd5,4'hF,32'hDEADBEEF),      idle,                                0,1,1,1,13'd5,    0,0,32'h0};
    tbl[1]  = '{r5,                                   idle,                                0,1,1,0,13'd5,    0,0,32'h0};
    tbl[2]  = '{idle,                                 idle,                                1,1,0,0,13'd0,    1,0,32'hDEADBEEF};
    tbl[3]  = '{idle,                                 rq(0,1,13'd10,4'hF,32'hFFFFFFFF),   1,0,1,1,13'd10,   0,0,32'h0};
    tbl[4]  = '{idle,                                 rq(0,1,13'd10,4'h5,32'h11223344),   1,0,1,1,13'd10,   0,0,32'h0};
    tbl[5]  = '{idle,                                 r10,                                 1,0,1,0,13'd10,   0,0,32'h0};
    tbl[6]  = '{idle,                                 idle,                                1,1,0,0,13'd0,    0,1,32'hFF22FF44};
    tbl[7]  = '{r5,                                   r10,                                 0,1,1,0,13'd5,    0,0,32'h0};
    tbl[8]  = '{r5,                                   r10,                                 1,0,1,0,13'd10,   1,0,32'hDEADBEEF};
    tbl[9]  = '{r5,                                   r10,                                 0,1,1,0,13'd5,    0,1,32'hFF22FF44};
    tbl[10] = '{r5,                                   r10,                                 1,0,1,0,13'd10,   1,0,32'hDEADBEEF};
    tbl[11] = '{r5,                                   r10,                                 0,1,1,0,13'd5,    0,1,32'hFF22FF44};
    tbl[12] = '{r5,                                   r10,                                 1,0,1,0,13'd10,   1,0,32'hDEADBEEF};
    tbl[13] = '{idle,                                 idle,                                1,1,0,0,13'd0,    0,1,32'hFF22FF44};
    tbl[14] = '{rq(0,1,13'd5120,4'hF,32'h1234),       idle,                                0,1,0,0,13'd5120, 0,0,32'h0};
    tbl[15] = '{rq(1,0,13'd5120,4'hF,32'h0),          idle,                                0,1,0,0,13'd5120, 0,0,32'h0};
    tbl[16] = '{idle,                                 idle,                                1,1,0,0,13'd0,    1,0,32'h0};
    tbl[17] = '{rq(1,1,13'd6,4'hF,32'hCAFEF00D),      idle,                                0,1,1,1,13'd6,    0,0,32'h0};
    tbl[18] = '{rq(1,0,13'd6,4'hF,32'h0),             idle,                                0,1,1,0,13'd6,    0,0,32'h0};
    tbl[19] = '{idle,                                 rq(1,0,13'd5121,4'hF,32'h0),        1,0,0,0,13'd5121, 1,0,32'hCAFEF00D};
    tbl[20] = '{idle,                                 idle,                                1,1,0,0,13'd0,    0,1,32'h0};
    tbl[21] = '{rq(0,1,13'd7,4'hF,32'h0A0A0A0A),      rq(0,1,13'd8,4'hF,32'h0B0B0B0B),    0,1,1,1,13'd7,    0,0,32'h0};
    tbl[22] = '{rq(0,1,13'd7,4'hF,32'h0A0A0A0A),      rq(0,1,13'd8,4'hF,32'h0B0B0B0B),    1,0,1,1,13'd8,    0,0,32'h0};
    tbl[23] = '{rq(1,0,13'd7,4'hF,32'h0),             idle,                                0,1,1,0,13'd7,    0,0,32'h0};
    tbl[24] = '{idle,                                 rq(1,0,13'd8,4'hF,32'h0),           1,0,1,0,13'd8,    1,0,32'h0A0A0A0A};
    tbl[25] = '{idle,                                 idle,                                1,1,0,0,13'd0,    0,1,32'h0B0B0B0B};

    // Reset: both requesters asking, nothing may be accepted.
    reset = 1'b1;
    clear_start = 1'b0;
    set_in(r5, r10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_w0", m0_waitrequest, 1'b1);
    chk("rst_w1", m1_waitrequest, 1'b1);
    chk("rst_cs", mem_chipselect, 1'b0);
    chk("rst_we", mem_write, 1'b0);
    chk("rst_busy", clear_busy, 1'b0);
    chk("rst_done", clear_done, 1'b0);
    chk("rst_rdv0", m0_readdatavalid, 1'b0);
    chk("rst_rdv1", m1_readdatavalid, 1'b0);
    tick();
    reset = 1'b0;
    set_in(idle, idle);
    @(negedge clk);
    chk("idle_w0", m0_waitrequest, 1'b1);
    chk("idle_rdv0", m0_readdatavalid, 1'b0);

    for (int i = 0; i < 26; i++) begin
      tick();
      set_in(tbl[i].q0, tbl[i].q1);
      @(negedge clk);
      chk($sformatf("v%0d_w0", i), m0_waitrequest, tbl[i].ew0);
      chk($sformatf("v%0d_w1", i), m1_waitrequest, tbl[i].ew1);
      chk($sformatf("v%0d_cs", i), mem_chipselect, tbl[i].ecs);
      chk($sformatf("v%0d_we", i), mem_write, tbl[i].ewe);
      chk($sformatf("v%0d_addr", i), mem_address, tbl[i].eaddr);
      chk($sformatf("v%0d_rdv0", i), m0_readdatavalid, tbl[i].erv0);
      chk($sformatf("v%0d_rdv1", i), m1_readdatavalid, tbl[i].erv1);
      if (tbl[i].erv0) chk($sformatf("v%0d_rd0", i), m0_readdata, tbl[i].erd);
      if (tbl[i].erv1) chk($sformatf("v%0d_rd1", i), m1_readdata, tbl[i].erd);
      if (!tbl[i].ew0) model_write(tbl[i].q0);
      else if (!tbl[i].ew1) model_write(tbl[i].q1);
      $display("vec %0d: w=%0b%0b cs=%0b we=%0b addr=%0d rdv=%0b%0b rdata=%08h", i,
               m0_waitrequest, m1_waitrequest, mem_chipselect, mem_write, mem_address,
               m0_readdatavalid, m1_readdatavalid, m0_readdata);
    end

    // Read just before clear_start, then clear with m0 asking throughout.
    tick();
    set_in(rq(1'b1, 1'b0, 13'd6, 4'hF, 32'h0), idle);
    @(negedge clk);
    chk("pre_clr_w0", m0_waitrequest, 1'b0);
    tick();
    set_in(rq(1'b1, 1'b0, 13'd0, 4'hF, 32'h0), idle);
    clear_start = 1'b1;
    @(negedge clk);
    chk("clr_start_w0", m0_waitrequest, 1'b1);
    chk("clr_start_rdv0", m0_readdatavalid, 1'b1);
    chk("clr_start_rd", m0_readdata, 32'hCAFEF00D);
    chk("clr_start_busy", clear_busy, 1'b0);
    $display("clear started");
    wait_cnt = 1;
    done_cnt = 0;
    bad_clr  = 0;
    for (int c = 0; c < 6000; c++) begin
      tick();
      clear_start = (c == 50);
      @(negedge clk);
      if (clear_done) done_cnt++;
      if (c == 0) chk("clr_busy_on", clear_busy, 1'b1);
      if (!m0_waitrequest) break;
      wait_cnt++;
      if (!(mem_chipselect && mem_write && mem_writedata == 32'h0 && mem_byteenable == 4'hF))
        bad_clr++;
    end
    chk("clr_wait_cycles", wait_cnt, 5121);
    chk("clr_bad_writes", bad_clr, 0);
    chk("clr_done_at_end", clear_done, 1'b1);
    chk("clr_busy_off", clear_busy, 1'b0);
    tick();
    set_in(idle, idle);
    @(negedge clk);
    if (clear_done) done_cnt++;
    chk("clr_done_once", done_cnt, 1);
    chk("clr_rd0_valid", m0_readdatavalid, 1'b1);
    chk("clr_rd0_data", m0_readdata, 32'h0);
    $display("clear finished after %0d blocked cycles", wait_cnt);
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    do_read(1'b0, 13'd5, 32'h0);
    do_read(1'b1, 13'd5119, 32'h0);

    // Reset in the middle of a clear.
    do_write(1'b1, 13'd3000, 4'hF, 32'h5A5A1234);
    tick();
    set_in(idle, idle);
    clear_start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 100; c++) begin
      tick();
      clear_start = 1'b0;
      @(negedge clk);
    end
    chk("mid_busy", clear_busy, 1'b1);
    tick();
    reset = 1'b1;
    set_in(rq(1'b1, 1'b0, 13'd3000, 4'hF, 32'h0), idle);
    @(negedge clk);
    chk("mid_rst_w0", m0_waitrequest, 1'b1);
    chk("mid_rst_cs", mem_chipselect, 1'b0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", clear_busy, 1'b0);
    chk("post_rst_done", clear_done, 1'b0);
    chk("post_rst_rdv0", m0_readdatavalid, 1'b0);
    chk("post_rst_w0", m0_waitrequest, 1'b0);
    tick();
    set_in(idle, idle);
    @(negedge clk);
    chk("post_rst_valid", m0_readdatavalid, 1'b1);
    chk("post_rst_data", m0_readdata, mdl[3000]);
    chk("post_rst_done2", clear_done, 1'b0);
    $display("reset mid-clear recovered, addr 3000 = %08h", m0_readdata);

    // Randomized traffic after a fresh reset; the first contention goes to m0.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last_id = 1;
    pend_v  = 1'b0;
    pend_id = 1'b0;
    pend_d  = 32'h0;
    for (int n = 0; n < 250; n++) begin
      req_t q[2];
      int   win;
      for (int k = 0; k < 2; k++) begin
        q[k].addr = ($urandom_range(0, 9) != 0) ? 13'($urandom_range(0, 15))
                                                : 13'($urandom_range(5118, 5125));
        q[k].rd   = ($urandom_range(0, 2) != 0);
        q[k].wr   = ($urandom_range(0, 2) == 0);
        q[k].be   = 4'($urandom_range(0, 15));
        q[k].data = $urandom;
      end
      tick();
      set_in(q[0], q[1]);
      @(negedge clk);
      if ((q[0].rd | q[0].wr) && (q[1].rd | q[1].wr)) win = 1 - last_id;
      else if (q[0].rd | q[0].wr) win = 0;
      else if (q[1].rd | q[1].wr) win = 1;
      else win = -1;
      chk("rnd_w0", m0_waitrequest, win != 0);
      chk("rnd_w1", m1_waitrequest, win != 1);
      chk("rnd_cs", mem_chipselect, win >= 0 && q[(win < 0) ? 0 : win].addr < DEPTH);
      chk("rnd_rdv0", m0_readdatavalid, pend_v && !pend_id);
      chk("rnd_rdv1", m1_readdatavalid, pend_v && pend_id);
      if (pend_v) chk("rnd_rdata", pend_id ? m1_readdata : m0_readdata, pend_d);
      pend_v = 1'b0;
      if (win >= 0) begin
        last_id = win;
        if (q[win].wr) begin
          model_write(q[win]);
        end else begin
          pend_v  = 1'b1;
          pend_id = (win == 1);
          pend_d  = (q[win].addr < DEPTH) ? mdl[q[win].addr] : 32'h0;
        end
        $display("rand %0d: m%0d %s addr=%0d", n, win, q[win].wr ? "wr" : "rd", q[win].addr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/de0_nano_onchip_memory_arbiter.md
Name: de0_nano_onchip_memory_arbiter

Overview:
Two-requester Avalon-MM arbiter placed in front of the single-port on-chip RAM (13-bit word address, 32-bit data, byte enables, 1-cycle read latency).
- Grants one access per cycle, round-robin.
- Generates a per-requester readdatavalid one cycle after each granted read.
- Blocks and ignores accesses beyond DEPTH.
- Provides a hardware clear sequencer that zero-fills the RAM on request.

Parameters:
- ADDR_W, 13, word address width of requesters and RAM.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 5120, number of implemented words; addresses at or above DEPTH are out of range.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- mN_address  in  ADDR_W  requester N word address (N = 0, 1; same set of ports per requester).
- mN_byteenable  in  DATA_W/8  requester N byte lanes.
- mN_read  in  1  requester N read request.
- mN_write  in  1  requester N write request.
- mN_writedata  in  DATA_W  requester N write data.
- mN_waitrequest  out  1  high = request not accepted this cycle.
- mN_readdata  out  DATA_W  read data.
- mN_readdatavalid  out  1  one-cycle pulse qualifying mN_readdata.
- mem_address  out  ADDR_W  to RAM address.
- mem_byteenable  out  DATA_W/8  to RAM byteenable.
- mem_chipselect  out  1  to RAM chipselect.
- mem_write  out  1  to RAM write.
- mem_writedata  out  DATA_W  to RAM writedata.
- mem_clken  out  1  to RAM clken; constant 1.
- mem_readdata  in  DATA_W  from RAM readdata (valid the cycle after the address is presented).
- clear_start  in  1  pulse: start zero-fill.
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse when clear completes.

Behaviour:
- Reset values:
  - state = RUN; rr_last = 1, so m0 wins the first contention.
  - clear counter = 0; in-flight tag cleared.
  - All readdatavalid = 0; clear_busy = 0; clear_done = 0.
  - mem_chipselect = 0; mem_write = 0.
  - Both waitrequest = 1 only while reset is high.
- A request is "active" when mN_read | mN_write. Read and write asserted together is treated as a write.
- Arbitration in RUN (combinational, per cycle):
  - If only one requester is active, it is granted.
  - If both are active, the one not equal to rr_last is granted.
  - Granted requester: waitrequest = 0. Every other requester: waitrequest = 1.
  - rr_last updates to the granted id on the next clock edge. It is unchanged when there is no grant.
- RAM drive:
  - In-range grant: mem_chipselect = 1; address, byteenable and writedata are muxed from the winner; mem_write = granted write.
  - No grant: mem_chipselect = 0; mem_write = 0; mux holds m0 fields.
- Out-of-range grant (address >= DEPTH):
  - Accepted (waitrequest = 0), but mem_chipselect = 0 and mem_write = 0.
  - A write is dropped.
  - A read returns 0 with the normal latency.
- Read latency:
  - A read granted in cycle T registers a tag {valid, id, oor}.
  - In T+1: m<id>_readdatavalid = 1; m<id>_readdata = oor ? 0 : mem_readdata.
  - Both readdata outputs follow the same mux; only readdatavalid is qualified.
  - Back-to-back reads, including alternating requesters, sustain 1 read per cycle.
- State machine RUN / CLEAR:
  - RUN -> CLEAR when clear_start = 1 in RUN.
    - The clear_start cycle issues no grant: both waitrequest = 1.
    - clear_busy goes high on the next cycle.
  - CLEAR:
    - Both waitrequest = 1.
    - Drive mem_chipselect = 1, mem_write = 1, byteenable all ones, writedata = 0, address = counter.
    - Counter increments by 1 per cycle.
  - CLEAR -> RUN after the write with counter = DEPTH-1.
    - clear_done pulses on the cycle after that write.
    - clear_busy drops in the same cycle; the counter returns to 0.
  - clear_start while in CLEAR is ignored.
- A read issued in the cycle before clear_start still returns its data in the following cycle (the tag is independent of state).
- Reset during CLEAR:
  - Returns to RUN immediately, with no clear_done.
  - RAM contents are partially cleared; this is expected.
  - The in-flight tag is discarded: no readdatavalid after reset.

Optional Feature:
Macro ONCHIP_ARB_STATS_EN.
- Defined:
  - Adds outputs m0_grant_count and m1_grant_count (16 bits each).
  - Adds output conflict_count (16 bits): cycles in which both requesters are active in RUN.
  - All counters saturate at 16'hFFFF and reset to 0.
  - Adds input stats_clear (1 bit), which zeroes all counters synchronously. stats_clear takes priority over a same-cycle increment.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package de0_nano_onchip_arb_pkg holds:
  - Requester-id typedef (1 bit).
  - State enum {RUN, CLEAR}.
  - Read-tag struct {valid, id, oor}.
  - Localparam BE_W = DATA_W/8.
- One sub-module, de0_nano_rr_arbiter2: 2-way round-robin grant logic (request vector in; grant one-hot and rr_last register out). The top instantiates it and holds the datapath mux, tag register and clear FSM.

Test Plan:
- Write from m0 only:
  - Stimulus: m0 writes 0xDEADBEEF to addr 5, byteenable 4'hF.
  - Required: waitrequest = 0 the same cycle; mem_write = 1 with mem_address = 5.
  - Then m0 reads addr 5. Required: m0_readdatavalid = 1 exactly one cycle later with 0xDEADBEEF; m1_readdatavalid stays 0.
- Contention: both requesters read continuously for 6 cycles.
  - Required: grants alternate m0, m1, m0, m1, m0, m1.
  - Each readdatavalid pulses on alternate cycles, one cycle after its grant; the loser sees waitrequest = 1.
- Byte write: m1 writes 0x11223344 with byteenable 4'b0101 over 0xFFFFFFFF, then reads back. Required: 0xFF22FF44.
- Out of range: m0 writes 0x1234 to addr 5120, then reads 5120. Required: mem_chipselect = 0 both cycles; readdatavalid pulses with data 0.
- Clear sequence:
  - Stimulus: pulse clear_start with m0 requesting throughout.
  - Required: m0_waitrequest = 1 for the clear_start cycle plus 5120 CLEAR cycles; clear_done pulses once; subsequent reads of addrs 0, 5 and 5119 return 0.
- Reset mid-clear: assert reset after 100 CLEAR cycles. Required: next cycle clear_busy = 0, no clear_done, and a new m0 read is granted after reset deasserts.
